lcd_frame_ctrl: RTL

LCD_FRAME_CTRL -- requirements
Module: lcd_frame_ctrl

---
 rtl/lcd_frame_ctrl.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_frame_ctrl.sv
// Dot-matrix LCD controller: bus-mapped command/data registers, paged frame RAM
// and an independent pixel scanout port.
module lcd_frame_ctrl #(
    parameter int unsigned NUM_COLS  = 132,
    parameter int unsigned NUM_PAGES = 9,
    parameter logic [23:0] CMD_ADDR  = 24'h20FE,
    parameter logic [23:0] DATA_ADDR = 24'h20FF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_ce,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [23:0] address_in,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic [5:0]  lcd_contrast,
    input  logic        scan_req,
    input  logic [7:0]  scan_x,
    input  logic [5:0]  scan_y,
    output logic        scan_valid,
    output logic        scan_pixel
);

    localparam int unsigned RAM_DEPTH = NUM_PAGES * NUM_COLS;
    localparam int unsigned AW        = $clog2(RAM_DEPTH);
    localparam int unsigned CW        = 8;
    localparam int unsigned PW        = 4;
    localparam int unsigned LW        = 6;

    localparam logic [CW-1:0] LAST_COL     = CW'(NUM_COLS - 1);
    localparam logic [PW-1:0] LAST_PAGE    = PW'(NUM_PAGES - 1);
    localparam logic [8:0]    COLS_W       = 9'(NUM_COLS);
    localparam logic [4:0]    PAGES_W      = 5'(NUM_PAGES);
    localparam logic [5:0]    CONTRAST_RST = 6'h20;
    localparam logic [5:0]    CONTRAST_MAX = 6'h3F;

    // Register state
    logic [CW-1:0] col_q, col_d;
    logic [PW-1:0] page_q, page_d;
    logic [CW-1:0] rmw_col_q, rmw_col_d;
    logic [LW-1:0] start_line_q, start_line_d;
    logic          seg_dir_q, seg_dir_d;
    logic          max_contrast_q, max_contrast_d;
    logic          all_on_q, all_on_d;
    logic          invert_q, invert_d;
    logic          display_en_q, display_en_d;
    logic          row_order_q, row_order_d;
    logic          rmw_q, rmw_d;
    logic          armed_q, armed_d;
    logic [5:0]    contrast_q, contrast_d;
    logic          wr_lat_q, rd_lat_q;
    logic [7:0]    rd_byte_q, rd_byte_d;
    logic          scan_valid_q, scan_valid_d;
    logic          scan_pixel_q, scan_pixel_d;

    logic [7:0]    mem_q [RAM_DEPTH];

    logic          wr_edge, rd_edge;
    logic          is_cmd, is_data;
    logic          col_ok, page_ok, bus_ok;
    logic [CW-1:0] col_eff;
    logic [AW-1:0] bus_idx;
    logic          mem_we;

    logic [LW-1:0] scan_row, scan_line;
    logic [AW-1:0] scan_idx;
    logic          scan_x_ok, scan_hit;
    logic [7:0]    scan_byte;
    logic          scan_bit;
    logic          pixel_val;

    // Strobe edge detection and address decode
    assign wr_edge = bus_write & ~wr_lat_q;
    assign rd_edge = bus_read & ~rd_lat_q;
    assign is_cmd  = (address_in == CMD_ADDR);
    assign is_data = (address_in == DATA_ADDR);

    // Bus-side RAM address; out-of-range page or column never touches RAM
    assign col_ok  = ({1'b0, col_q} < COLS_W);
    assign page_ok = ({1'b0, page_q} < PAGES_W);
    assign bus_ok  = col_ok & page_ok;
    assign col_eff = seg_dir_q ? (LAST_COL - col_q) : col_q;
    assign bus_idx = AW'(32'(page_q) * NUM_COLS + 32'(col_eff));
    assign mem_we  = clk_ce & wr_edge & is_data & ~armed_q & bus_ok;

    // Scanout address: visible row mapped through row order and start line
    assign scan_row  = row_order_q ? (6'd63 - scan_y) : scan_y;
    assign scan_line = scan_row + start_line_q;
    assign scan_idx  = AW'(32'(scan_line[5:3]) * NUM_COLS + 32'(scan_x));
    assign scan_x_ok = ({1'b0, scan_x} < COLS_W);
    assign scan_hit  = scan_x_ok & ({2'b00, scan_line[5:3]} < PAGES_W);
    assign scan_byte = scan_hit ? mem_q[scan_idx] : 8'h00;
    assign scan_bit  = scan_byte[scan_line[2:0]];

    always_comb begin
        pixel_val = 1'b0;
        if (scan_x_ok && display_en_q) begin
            pixel_val = all_on_q ? 1'b1 : (scan_bit ^ invert_q);
        end
    end

    // Next-state logic for bus commands, data accesses and scanout
    always_comb begin
        col_d          = col_q;
        page_d         = page_q;
        rmw_col_d      = rmw_col_q;
        start_line_d   = start_line_q;
        seg_dir_d      = seg_dir_q;
        max_contrast_d = max_contrast_q;
        all_on_d       = all_on_q;
        invert_d       = invert_q;
        display_en_d   = display_en_q;
        row_order_d    = row_order_q;
        rmw_d          = rmw_q;
        armed_d        = armed_q;
        contrast_d     = contrast_q;
        rd_byte_d      = bus_ok ? mem_q[bus_idx] : 8'h00;
        scan_valid_d   = scan_req;
        scan_pixel_d   = scan_req ? pixel_val : scan_pixel_q;

        if (wr_edge) begin
            if (armed_q && (is_cmd || is_data)) begin
                contrast_d = data_in[5:0];
                armed_d    = 1'b0;
            end else if (is_cmd) begin
                casez (data_in)
                    8'b0000_????: if (!rmw_q) col_d = {col_q[7:4], data_in[3:0]};
                    8'b0001_????: if (!rmw_q) col_d = {data_in[3:0], col_q[3:0]};
                    8'b01??_????: start_line_d = data_in[5:0];
                    8'b1000_0001: armed_d = 1'b1;
                    8'b1010_000?: seg_dir_d = data_in[0];
                    8'b1010_001?: max_contrast_d = data_in[0];
                    8'b1010_010?: all_on_d = data_in[0];
                    8'b1010_011?: invert_d = data_in[0];
                    8'b1010_111?: display_en_d = data_in[0];
                    8'b1011_????: page_d = data_in[3:0];
                    8'b1100_????: row_order_d = data_in[3];
                    8'b1110_0000: begin
                        if (!rmw_q) rmw_col_d = col_q;
                        rmw_d = 1'b1;
                    end
                    8'b1110_1110: begin
                        col_d = rmw_col_q;
                        rmw_d = 1'b0;
                    end
                    8'b1110_0010: begin
                        col_d          = '0;
                        page_d         = '0;
                        rmw_col_d      = '0;
                        start_line_d   = '0;
                        seg_dir_d      = 1'b0;
                        max_contrast_d = 1'b0;
                        all_on_d       = 1'b0;
                        invert_d       = 1'b0;
                        display_en_d   = 1'b0;
                        row_order_d    = 1'b0;
                        rmw_d          = 1'b0;
                        armed_d        = 1'b0;
                        contrast_d     = CONTRAST_RST;
                    end
                    default: ;
                endcase
            end else if (is_data) begin
                if (col_q < LAST_COL) col_d = col_q + 8'd1;
            end
        end else if (rd_edge) begin
            if (is_cmd && armed_q) begin
                contrast_d = CONTRAST_MAX;
                armed_d    = 1'b0;
            end else if (is_data && !rmw_q && (col_q < LAST_COL)) begin
                col_d = col_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q          <= '0;
            page_q         <= '0;
            rmw_col_q      <= '0;
            start_line_q   <= '0;
            seg_dir_q      <= 1'b0;
            max_contrast_q <= 1'b0;
            all_on_q       <= 1'b0;
            invert_q       <= 1'b0;
            display_en_q   <= 1'b0;
            row_order_q    <= 1'b0;
            rmw_q          <= 1'b0;
            armed_q        <= 1'b0;
            contrast_q     <= CONTRAST_RST;
            wr_lat_q       <= 1'b0;
            rd_lat_q       <= 1'b0;
            rd_byte_q      <= 8'h00;
            scan_valid_q   <= 1'b0;
            scan_pixel_q   <= 1'b0;
        end else if (clk_ce) begin
            col_q          <= col_d;
            page_q         <= page_d;
            rmw_col_q      <= rmw_col_d;
            start_line_q   <= start_line_d;
            seg_dir_q      <= seg_dir_d;
            max_contrast_q <= max_contrast_d;
            all_on_q       <= all_on_d;
            invert_q       <= invert_d;
            display_en_q   <= display_en_d;
            row_order_q    <= row_order_d;
            rmw_q          <= rmw_d;
            armed_q        <= armed_d;
            contrast_q     <= contrast_d;
            wr_lat_q       <= bus_write;
            rd_lat_q       <= bus_read;
            rd_byte_q      <= rd_byte_d;
            scan_valid_q   <= scan_valid_d;
            scan_pixel_q   <= scan_pixel_d;
        end
    end

    // Frame RAM contents survive both resets
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[bus_idx] <= data_in;
    end

    // Read mux: last page carries a single pixel row
    always_comb begin
        data_out = 8'h00;
        if (!armed_q) begin
            if (is_data) begin
                if (page_q < LAST_PAGE)       data_out = rd_byte_q;
                else if (page_q == LAST_PAGE) data_out = {7'b0, rd_byte_q[0]};
            end else if (is_cmd) begin
                data_out = 8'h40 | {2'b00, display_en_q, 5'b00000};
            end
        end
    end

    assign lcd_contrast = max_contrast_q ? CONTRAST_MAX : contrast_q;
    assign scan_valid   = scan_valid_q;
    assign scan_pixel   = scan_pixel_q;

endmodule
